// File: rtl/icache_refill_unit_pkg.sv
// Shared definitions for the instruction-cache refill unit: two-way line
// layout, address field widths and the refill FSM state encoding.
package icache_refill_unit_pkg;

  localparam int WORD_W    = 32;
  localparam int LINE_W    = 109;
  localparam int INDEX_W   = 10;
  localparam int INDEX_LSB = 2;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_W;
  localparam int TAG_W     = 32 - TAG_LSB;

  // Way 1 occupies the upper half of the line and also carries the LRU bit.
  localparam int W1_VALID    = 108;
  localparam int W1_LRU      = 107;
  localparam int W1_RSVD     = 106;
  localparam int W1_TAG_MSB  = 105;
  localparam int W1_TAG_LSB  = 86;
  localparam int W1_DATA_MSB = 85;
  localparam int W1_DATA_LSB = 54;

  localparam int W0_VALID    = 53;
  localparam int W0_RSVD     = 52;
  localparam int W0_TAG_MSB  = 51;
  localparam int W0_TAG_LSB  = 32;
  localparam int W0_DATA_MSB = 31;
  localparam int W0_DATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[TAG_LSB +: TAG_W];
  endfunction

endpackage

// File: rtl/icache_line_merge.sv
// Combinational victim selection and line rebuild for one refill word.
// Hit way is refreshed in place, else first invalid way (way0 first), else
// the LRU victim; LRU then points at the way that was not written.
module icache_line_merge
  import icache_refill_unit_pkg::*;
(
  input  logic [LINE_W-1:0] line_in,
  input  logic [31:0]       addr_in,
  input  logic [WORD_W-1:0] data_in,
  output logic [LINE_W-1:0] line_out
);

  logic [TAG_W-1:0] req_tag;
  logic [TAG_W-1:0] tag0;
  logic [TAG_W-1:0] tag1;
  logic             valid0;
  logic             valid1;
  logic             lru;
  logic             hit0;
  logic             hit1;
  logic             victim1;

  // Offset/index bits and incoming reserved bits play no part in the merge.
  logic [TAG_LSB-1:0] unused_addr_lo;
  logic [1:0]         unused_rsvd;

  assign unused_addr_lo = addr_in[TAG_LSB-1:0];
  assign unused_rsvd    = {line_in[W1_RSVD], line_in[W0_RSVD]};

  assign req_tag = addr_tag(addr_in);
  assign tag0    = line_in[W0_TAG_MSB:W0_TAG_LSB];
  assign tag1    = line_in[W1_TAG_MSB:W1_TAG_LSB];
  assign valid0  = line_in[W0_VALID];
  assign valid1  = line_in[W1_VALID];
  assign lru     = line_in[W1_LRU];
  assign hit0    = valid0 && (tag0 == req_tag);
  assign hit1    = valid1 && (tag1 == req_tag);

  // Pick the way to overwrite: hit, then first invalid, then LRU.
  always_comb begin
    victim1 = 1'b0;
    if (hit0)         victim1 = 1'b0;
    else if (hit1)    victim1 = 1'b1;
    else if (!valid0) victim1 = 1'b0;
    else if (!valid1) victim1 = 1'b1;
    else              victim1 = lru;
  end

  // Rebuild the line: copy the untouched way, overwrite the victim.
  always_comb begin
    line_out          = line_in;
    line_out[W1_RSVD] = 1'b0;
    line_out[W0_RSVD] = 1'b0;
    line_out[W1_LRU]  = ~victim1;
    if (victim1) begin
      line_out[W1_VALID]                = 1'b1;
      line_out[W1_TAG_MSB:W1_TAG_LSB]   = req_tag;
      line_out[W1_DATA_MSB:W1_DATA_LSB] = data_in;
    end else begin
      line_out[W0_VALID]                = 1'b1;
      line_out[W0_TAG_MSB:W0_TAG_LSB]   = req_tag;
      line_out[W0_DATA_MSB:W0_DATA_LSB] = data_in;
    end
  end

endmodule

// File: rtl/icache_refill_unit.sv
// Instruction-cache miss refill unit: accepts one miss, reads one word from
// backing memory, and emits the updated two-way line for write-back.
// Optional memory-ack watchdog compiled in with `define REFILL_TIMEOUT_EN.
module icache_refill_unit
  import icache_refill_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
)
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [LINE_W-1:0] req_line,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              fill_valid,
  output logic [31:0]       fill_addr,
  output logic [LINE_W-1:0] fill_line,
  output logic              busy
`ifdef REFILL_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  state_t            state;
  logic [31:0]       addr_p0;
  logic [LINE_W-1:0] line_p0;
  logic [LINE_W-1:0] merged_line;
  logic              accept;
  logic              wd_expire;

  assign accept = (state == ST_IDLE) && req_valid && req_ready;

`ifdef REFILL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;

  // A late ack on the limit cycle still completes the refill.
  assign wd_expire   = (state == ST_REQ) && !mem_ack && (wd_cnt == CNT_LIMIT);
  assign timeout_err = wd_expire;

  // Watchdog: held at zero outside REQ, counts REQ cycles spent waiting.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wd_cnt <= '0;
    end else if (state != ST_REQ) begin
      wd_cnt <= '0;
    end else if (!mem_ack) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign wd_expire             = 1'b0;
`endif

  // Capture the miss context on acceptance; later input changes are ignored.
  always_ff @(posedge CLK) begin
    if (accept) begin
      addr_p0 <= req_addr;
      line_p0 <= req_line;
    end
  end

  icache_line_merge u_merge (
    .line_in  (line_p0),
    .addr_in  (addr_p0),
    .data_in  (mem_rdata),
    .line_out (merged_line)
  );

  // Refill FSM with registered handshake and fill outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_line  <= '0;
      busy       <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_req   <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            fill_valid <= 1'b1;
            fill_addr  <= addr_p0;
            fill_line  <= merged_line;
            state      <= ST_FILL;
          end else if (wd_expire) begin
            mem_req   <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_FILL: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          mem_req   <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: table of refill transactions with
// hand-computed result lines, plus multi-cycle handshake and reset sequences.
module tb_icache_refill_unit;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic [108:0] req_line;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [108:0] fill_line;
  logic         busy;
`ifdef REFILL_TIMEOUT_EN
  logic         timeout_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  icache_refill_unit #(.TIMEOUT_CYCLES(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_line   (req_line),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_line  (fill_line),
    .busy       (busy)
`ifdef REFILL_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  typedef struct {
    string        name;
    logic [31:0]  addr;
    logic [108:0] line;
    logic [31:0]  rdata;
    int           delay;
    logic [108:0] exp_line;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [108:0] mk_raw(input logic v1, input logic lru, input logic r1,
                                          input logic [19:0] t1, input logic [31:0] d1,
                                          input logic v0, input logic r0,
                                          input logic [19:0] t0, input logic [31:0] d0);
    return {v1, lru, r1, t1, d1, v0, r0, t0, d0};
  endfunction

  function automatic logic [108:0] mk_line(input logic v1, input logic lru,
                                           input logic [19:0] t1, input logic [31:0] d1,
                                           input logic v0, input logic [19:0] t0,
                                           input logic [31:0] d0);
    return mk_raw(v1, lru, 1'b0, t1, d1, v0, 1'b0, t0, d0);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    // Accept in IDLE.
    chk({v.name, ".ready_idle"}, 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_line  = v.line;
    step();
    // First REQ cycle; disturb inputs to prove they were latched.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_line  = {$urandom, $urandom, $urandom, $urandom};
    chk({v.name, ".mem_req"},  128'(mem_req),  128'(1));
    chk({v.name, ".mem_addr"}, 128'(mem_addr), 128'({v.addr[31:2], 2'b00}));
    chk({v.name, ".busy"},     128'(busy),     128'(1));
    chk({v.name, ".ready_req"}, 128'(req_ready), 128'(0));
    for (int k = 0; k < v.delay; k++) begin
      step();
      chk({v.name, ".mem_req_hold"},  128'(mem_req),    128'(1));
      chk({v.name, ".mem_addr_hold"}, 128'(mem_addr),   128'({v.addr[31:2], 2'b00}));
      chk({v.name, ".no_fill_req"},   128'(fill_valid), 128'(0));
    end
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    chk({v.name, ".fill_valid"}, 128'(fill_valid), 128'(1));
    chk({v.name, ".fill_addr"},  128'(fill_addr),  128'(v.addr));
    chk({v.name, ".fill_line"},  128'(fill_line),  128'(v.exp_line));
    chk({v.name, ".mem_req_fill"}, 128'(mem_req),  128'(0));
    step();
    chk({v.name, ".fill_pulse"}, 128'(fill_valid), 128'(0));
    chk({v.name, ".line_hold"},  128'(fill_line),  128'(v.exp_line));
    chk({v.name, ".ready_back"}, 128'(req_ready),  128'(1));
    chk({v.name, ".idle_busy"},  128'(busy),       128'(0));
  endtask

  initial begin
    int fills;

    vecs[0] = '{"v0_empty", 32'h0000_1004, 109'd0, 32'hDEADBEEF, 3,
                mk_line(0, 1, 20'h0, 32'h0, 1, 20'h00001, 32'hDEADBEEF)};
    vecs[1] = '{"v1_lru0_evict", 32'h0000_4008,
                mk_line(1, 0, 20'h00003, 32'h11111111, 1, 20'h00002, 32'h22222222), 32'hCAFEF00D, 0,
                mk_line(1, 1, 20'h00003, 32'h11111111, 1, 20'h00004, 32'hCAFEF00D)};
    vecs[2] = '{"v2_hit_way1", 32'h0000_502C,
                mk_line(1, 1, 20'h00005, 32'hAAAA0000, 1, 20'h00006, 32'hBBBB0000), 32'h12345678, 1,
                mk_line(1, 0, 20'h00005, 32'h12345678, 1, 20'h00006, 32'hBBBB0000)};
    vecs[3] = '{"v3_way1_invalid", 32'h0000_9010,
                mk_line(0, 0, 20'h0, 32'h0, 1, 20'h00007, 32'h77777777), 32'h99990000, 2,
                mk_line(1, 0, 20'h00009, 32'h99990000, 1, 20'h00007, 32'h77777777)};
    vecs[4] = '{"v4_lru1_evict", 32'h0000_C3FC,
                mk_line(1, 1, 20'h0000B, 32'hBBBBBBBB, 1, 20'h0000A, 32'hAAAAAAAA), 32'h0C0C0C0C, 0,
                mk_line(1, 0, 20'h0000C, 32'h0C0C0C0C, 1, 20'h0000A, 32'hAAAAAAAA)};
    vecs[5] = '{"v5_hit_way0", 32'h0000_D000,
                mk_line(1, 0, 20'h0000E, 32'hEEEEEEEE, 1, 20'h0000D, 32'hDDDDDDDD), 32'h5A5A5A5A, 1,
                mk_line(1, 1, 20'h0000E, 32'hEEEEEEEE, 1, 20'h0000D, 32'h5A5A5A5A)};
    vecs[6] = '{"v6_stale_rsvd", 32'h0000_F007,
                mk_raw(1, 1, 1, 20'h00001, 32'h10101010, 0, 1, 20'h0000F, 32'h0BAD0BAD), 32'h01020304, 0,
                mk_line(1, 1, 20'h00001, 32'h10101010, 1, 20'h0000F, 32'h01020304)};
    vecs[7] = '{"v7_top_tag", 32'hFFFF_FFFC,
                mk_line(0, 1, 20'h0, 32'h0, 0, 20'h0, 32'h0), 32'hFFFFFFFF, 1,
                mk_line(0, 1, 20'h0, 32'h0, 1, 20'hFFFFF, 32'hFFFFFFFF)};

    RESET     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_line  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    step();
    step();
    chk("rst.req_ready",  128'(req_ready),  128'(1));
    chk("rst.mem_req",    128'(mem_req),    128'(0));
    chk("rst.mem_addr",   128'(mem_addr),   128'(0));
    chk("rst.fill_valid", 128'(fill_valid), 128'(0));
    chk("rst.fill_addr",  128'(fill_addr),  128'(0));
    chk("rst.fill_line",  128'(fill_line),  128'(0));
    chk("rst.busy",       128'(busy),       128'(0));
`ifdef REFILL_TIMEOUT_EN
    chk("rst.timeout_err", 128'(timeout_err), 128'(0));
`endif
    RESET = 1'b1;
    step();
    chk("rel.req_ready", 128'(req_ready), 128'(1));
    chk("rel.busy",      128'(busy),      128'(0));

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // req_valid held through the whole refill: only one fill may result.
    fills     = 0;
    req_valid = 1'b1;
    req_addr  = 32'h0002_0000;
    req_line  = '0;
    step();
    for (int k = 0; k < 3; k++) begin
      req_addr = 32'h0003_0000 + 32'(k * 4);
      chk("held.ready_req", 128'(req_ready), 128'(0));
      fills += int'(fill_valid);
      step();
    end
    chk("held.ready_req_last", 128'(req_ready), 128'(0));
    mem_ack   = 1'b1;
    mem_rdata = 32'h600DF00D;
    step();
    mem_ack = 1'b0;
    fills += int'(fill_valid);
    chk("held.ready_fill", 128'(req_ready), 128'(0));
    chk("held.fill_line", 128'(fill_line),
        128'(mk_line(0, 1, 20'h0, 32'h0, 1, 20'h00020, 32'h600DF00D)));
    chk("held.fill_addr", 128'(fill_addr), 128'(32'h0002_0000));
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      fills += int'(fill_valid);
    end
    chk("held.one_fill", 128'(fills), 128'(1));
    chk("held.mem_req_idle", 128'(mem_req), 128'(0));

    // Reset while waiting for memory, with an ack arriving in the same cycle.
    req_valid = 1'b1;
    req_addr  = 32'h0005_0010;
    req_line  = '0;
    step();
    req_valid = 1'b0;
    step();
    chk("rstreq.in_req", 128'(mem_req), 128'(1));
    RESET     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BADF00D;
    step();
    chk("rstreq.mem_req",    128'(mem_req),    128'(0));
    chk("rstreq.busy",       128'(busy),       128'(0));
    chk("rstreq.fill_valid", 128'(fill_valid), 128'(0));
    chk("rstreq.req_ready",  128'(req_ready),  128'(1));
    chk("rstreq.fill_line",  128'(fill_line),  128'(0));
    chk("rstreq.mem_addr",   128'(mem_addr),   128'(0));
    RESET = 1'b1;
    step();
    chk("rstreq.ack_idle_nofill", 128'(fill_valid), 128'(0));
    chk("rstreq.ack_idle_busy",   128'(busy),       128'(0));
    mem_ack = 1'b0;
    step();
    chk("rstreq.still_nofill", 128'(fill_valid), 128'(0));
    chk("rstreq.mem_req_off",  128'(mem_req),    128'(0));

`ifdef REFILL_TIMEOUT_EN
    // Watchdog with limit 8 and no ack at all.
    fills     = 0;
    req_valid = 1'b1;
    req_addr  = 32'h0004_0000;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("to.err_cycle", 128'(timeout_err), 128'(k == 8));
      chk("to.mem_req",   128'(mem_req),     128'(1));
      fills += int'(fill_valid);
      if (k < 8) step();
    end
    step();
    fills += int'(fill_valid);
    chk("to.err_pulse", 128'(timeout_err), 128'(0));
    chk("to.mem_drop",  128'(mem_req),     128'(0));
    chk("to.idle",      128'(busy),        128'(0));
    chk("to.ready",     128'(req_ready),   128'(1));
    step();
    fills += int'(fill_valid);
    chk("to.no_fill",   128'(fills),       128'(0));
`endif

    // Recovery: a normal refill still works after the corner cases.
    run_vec(vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
